// File: rtl/sync_fifo_fwft_reader.sv
// Read-side adapter for sync_fifo: issues fifo_ren on credit and turns the
// one-cycle read latency into a first-word-fall-through valid/ready stream.
module sync_fifo_fwft_reader #(
  parameter int FIFO_WIDTH = 8
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rst,
  output logic                  fifo_ren,
  input  logic [FIFO_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            buf_level
);

  logic                  r_infl;
  logic [1:0]            r_level;
  logic [FIFO_WIDTH-1:0] r_head;
  logic [FIFO_WIDTH-1:0] r_tail;

  logic                  w_pop;
  logic [2:0]            w_credit;
  logic [1:0]            w_level_nx;
  logic [FIFO_WIDTH-1:0] w_head_nx;
  logic [FIFO_WIDTH-1:0] w_tail_nx;

  assign w_pop     = m_valid & m_ready;
  assign m_valid   = (r_level != 2'd0);
  assign m_data    = r_head;
  assign buf_level = r_level;

  // Words held plus the one in flight, minus the one leaving now.
  assign w_credit = {1'b0, r_level}
                  + {2'b00, r_infl}
                  - {2'b00, w_pop};

  assign fifo_ren = fifo_rst & ~fifo_empty
                  & (w_credit < 3'd2);

  always_comb begin
    w_level_nx = r_level;
    w_head_nx  = r_head;
    w_tail_nx  = r_tail;
    unique case (1'b1)
      (r_infl & ~w_pop): begin
        w_level_nx = r_level + 2'd1;
        if (r_level == 2'd0)
          w_head_nx = fifo_rdata;
        else
          w_tail_nx = fifo_rdata;
      end
      (~r_infl & w_pop): begin
        w_level_nx = r_level - 2'd1;
        w_head_nx  = r_tail;
      end
      (r_infl & w_pop): begin
        if (r_level == 2'd1) begin
          w_head_nx = fifo_rdata;
        end else begin
          w_head_nx = r_tail;
          w_tail_nx = fifo_rdata;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge fifo_clk or negedge fifo_rst) begin
    if (!fifo_rst) begin
      r_infl  <= 1'b0;
      r_level <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_infl  <= fifo_ren;
      r_level <= w_level_nx;
      r_head  <= w_head_nx;
      r_tail  <= w_tail_nx;
    end
  end

endmodule

// File: tb/tb_sync_fifo_fwft_reader.sv
// Bench for sync_fifo_fwft_reader: a queue-based depth-8 FIFO with one-cycle
// read latency feeds the adapter; received words are logged and compared.
module tb_sync_fifo_fwft_reader;

  logic       fifo_clk = 1'b0;
  logic       fifo_rst = 1'b0;
  logic       fifo_ren;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_full  = 1'b0;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic [1:0] buf_level;

  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_pend = 1'b0;
  bit         wr_busy = 1'b0;

  logic [7:0] q[$];
  logic [7:0] rx_log[$];
  logic [7:0] sent_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int ren_cnt = 0;
  int n_ren_empty = 0;
  int n_ovf = 0;

  sync_fifo_fwft_reader #(.FIFO_WIDTH(8)) u_dut (
    .fifo_clk   (fifo_clk),
    .fifo_rst   (fifo_rst),
    .fifo_ren   (fifo_ren),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .buf_level  (buf_level)
  );

  always #5 fifo_clk = ~fifo_clk;

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Environment FIFO: depth 8, registered empty/full, data the cycle after ren.
  always @(posedge fifo_clk) begin
    rd_pend <= 1'b0;
    if (fifo_ren) ren_cnt <= ren_cnt + 1;
    if (fifo_ren && q.size() > 0) begin
      fifo_rdata <= q.pop_front();
      rd_pend    <= 1'b1;
    end
    if (wr_en && q.size() < 8) q.push_back(wr_data);
    fifo_empty <= (q.size() == 0);
    fifo_full  <= (q.size() == 8);
  end

  always @(negedge fifo_clk) begin
    #2;
    if (fifo_rst) begin
      if (m_valid && m_ready) rx_log.push_back(m_data);
      if (fifo_ren && fifo_empty) n_ren_empty <= n_ren_empty + 1;
      if (rd_pend && buf_level == 2'd2 && !(m_valid && m_ready))
        n_ovf <= n_ovf + 1;
    end
  end

  task automatic write_seq(input int base, input int n, input bit rnd);
    int k = 0;
    wr_busy = 1'b1;
    while (k < n) begin
      @(negedge fifo_clk);
      if (!fifo_full) begin
        wr_en   = 1'b1;
        wr_data = rnd ? 8'($urandom) : 8'(base + k);
        sent_q.push_back(wr_data);
        k++;
      end else begin
        wr_en = 1'b0;
      end
    end
    @(negedge fifo_clk);
    wr_en   = 1'b0;
    wr_busy = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string tag);
    int c = 0;
    while (rx_log.size() < n && c < 4000) begin
      @(negedge fifo_clk);
      #3;
      c++;
    end
    chk(tag, rx_log.size(), n);
  endtask

  task automatic wait_wr();
    int c = 0;
    while (wr_busy && c < 4000) begin
      @(negedge fifo_clk);
      c++;
    end
    chk("wr_done", int'(wr_busy), 0);
  endtask

  initial begin
    int ren0;
    int bad;
    int c;
    int exp_n;
    logic [7:0] head;

    // Reset held with words queued in the FIFO.
    write_seq(8'h10, 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge fifo_clk);
      #2;
      chk("rst_ren", int'(fifo_ren), 0);
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_data", int'(m_data), 0);
      chk("rst_lvl", int'(buf_level), 0);
    end
    @(negedge fifo_clk);
    rx_log.delete();
    fifo_rst = 1'b1;
    m_ready  = 1'b1;
    wait_rx(3, "t1_rx");
    for (int i = 0; i < 3; i++)
      chk("t1_data", int'(rx_log[i]), 16 + i);
    @(negedge fifo_clk);
    m_ready = 1'b0;

    // Single word, downstream stalled.
    repeat (3) @(negedge fifo_clk);
    rx_log.delete();
    ren0 = ren_cnt;
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    @(negedge fifo_clk);
    wr_en = 1'b0;
    #2;
    chk("t2_ren_hi", int'(fifo_ren), 1);
    @(negedge fifo_clk);
    #2;
    chk("t2_ren_lo", int'(fifo_ren), 0);
    chk("t2_valid_lat", int'(m_valid), 0);
    @(negedge fifo_clk);
    #2;
    chk("t2_valid", int'(m_valid), 1);
    chk("t2_data", int'(m_data), 8'hA5);
    chk("t2_lvl", int'(buf_level), 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge fifo_clk);
      #2;
      if (!m_valid || m_data != 8'hA5 || buf_level != 2'd1) bad++;
    end
    chk("t2_hold", bad, 0);
    chk("t2_ren_pulses", ren_cnt - ren0, 1);
    @(negedge fifo_clk);
    m_ready = 1'b1;
    @(negedge fifo_clk);
    m_ready = 1'b0;
    #3;
    chk("t2_rx_n", rx_log.size(), 1);
    chk("t2_rx", int'(rx_log[0]), 8'hA5);

    // Full-rate stream.
    repeat (2) @(negedge fifo_clk);
    rx_log.delete();
    m_ready = 1'b1;
    fork
      write_seq(0, 64, 1'b0);
    join_none
    c = 0;
    @(negedge fifo_clk);
    #2;
    while (!m_valid && c < 50) begin
      @(negedge fifo_clk);
      #2;
      c++;
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (!m_valid) bad++;
      @(negedge fifo_clk);
      #2;
    end
    chk("t3_gaps", bad, 0);
    wait_wr();
    wait_rx(64, "t3_rx_n");
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (int'(rx_log[i]) != i) bad++;
    chk("t3_order", bad, 0);

    // Backpressure with 8 words written.
    @(negedge fifo_clk);
    m_ready = 1'b0;
    rx_log.delete();
    ren0 = ren_cnt;
    write_seq(0, 8, 1'b0);
    repeat (4) @(negedge fifo_clk);
    #2;
    chk("t4_pulses", ren_cnt - ren0, 2);
    chk("t4_lvl", int'(buf_level), 2);
    chk("t4_fifo_n", q.size(), 6);
    chk("t4_ren_off", int'(fifo_ren), 0);
    @(negedge fifo_clk);
    m_ready = 1'b1;
    wait_rx(8, "t4_rx_n");
    for (int i = 0; i < 8; i++)
      chk("t4_data", int'(rx_log[i]), i);

    // Random backpressure against a greedy writer.
    @(negedge fifo_clk);
    rx_log.delete();
    sent_q.delete();
    fork
      write_seq(0, 1000, 1'b1);
      begin
        int k = 0;
        while (rx_log.size() < 1000 && k < 20000) begin
          @(negedge fifo_clk);
          m_ready = 1'($urandom_range(0, 1));
          k++;
        end
        m_ready = 1'b1;
      end
    join
    chk("t5_rx_n", rx_log.size(), 1000);
    bad = 0;
    for (int i = 0; i < 1000 && i < rx_log.size(); i++)
      if (rx_log[i] != sent_q[i]) bad++;
    chk("t5_order", bad, 0);

    // Asynchronous reset mid-stream with a full skid buffer.
    @(negedge fifo_clk);
    rx_log.delete();
    m_ready = 1'b1;
    fork
      write_seq(8'h40, 40, 1'b0);
    join_none
    repeat (8) @(negedge fifo_clk);
    m_ready = 1'b0;
    c = 0;
    #2;
    while (buf_level != 2'd2 && c < 20) begin
      @(negedge fifo_clk);
      #2;
      c++;
    end
    chk("t6_lvl2", int'(buf_level), 2);
    repeat (3) @(negedge fifo_clk);
    @(posedge fifo_clk);
    #3;
    head = (q.size() > 0) ? q[0] : 8'h68;
    fifo_rst = 1'b0;
    #1;
    chk("t6_valid_drop", int'(m_valid), 0);
    chk("t6_lvl0", int'(buf_level), 0);
    chk("t6_ren0", int'(fifo_ren), 0);
    repeat (2) @(negedge fifo_clk);
    rx_log.delete();
    fifo_rst = 1'b1;
    m_ready  = 1'b1;
    exp_n = 8'h68 - int'(head);
    wait_wr();
    wait_rx(exp_n, "t6_rx_n");
    chk("t6_first", int'(rx_log[0]), int'(head));
    bad = 0;
    for (int i = 0; i < rx_log.size(); i++)
      if (int'(rx_log[i]) != int'(head) + i) bad++;
    chk("t6_order", bad, 0);

    repeat (4) @(negedge fifo_clk);
    chk("ren_when_empty", n_ren_empty, 0);
    chk("overflow", n_ovf, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
